mtimer: RTL and testbench

Memory-mapped RISC-V machine timer: a free-running 64-bit MTIME counter, a 64-bit MTIMECMP compare register, and the registered level `timer` that feeds the core's interrupt controller as the machine timer interrupt source (MIP.MTIP). It sits on the core data bus as a slave. Unmapped accesses are reported through `fault`, which the core routes to its load/store access-fault path. Counting freezes while the core is halted in debug mode.

---
 rtl/mtimer.sv | 142 ++++++++++++++
 tb/tb_mtimer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mtimer.sv
// rtl/mtimer.sv - RISC-V machine timer (MTIME/MTIMECMP, timer level); define MTIMER_PRESCALER_EN for PRESCALE at 0x10
module mtimer #(
    parameter logic [31:0] BASE = 32'h0200_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        fault,
    input  logic        halt,
    output logic        timer
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [2:0]  word;
    logic        access;
    logic        mapped;
    logic        bad;
    logic        rd_ok;
    logic        wr_ok;
    logic        tick;
    logic [31:0] rd_val;
    logic [28:0] unused_addr_bits;

    // Only the word index inside the 32-byte window matters; BASE is 32-byte aligned.
    assign unused_addr_bits = {addr[31:5], addr[1:0]};
    assign word   = addr[4:2] - BASE[4:2];
    assign access = sel & (rd | wr);

`ifdef MTIMER_PRESCALER_EN
    assign mapped = (word <= 3'd4);
`else
    assign mapped = (word <= 3'd3);
`endif

    // Simultaneous rd+wr is treated as a malformed access, same as an unmapped offset.
    assign bad   = access & ((rd & wr) | !mapped);
    assign rd_ok = sel & rd & !wr & mapped;
    assign wr_ok = sel & wr & !rd & mapped;

    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  byte_en);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = byte_en[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

`ifdef MTIMER_PRESCALER_EN
    logic [15:0] prescale;
    logic [15:0] pcnt;

    assign tick = !halt && (pcnt == prescale);

    // Prescale register and divider; a PRESCALE write restarts the divide period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescale <= 16'h0;
            pcnt     <= 16'h0;
        end else if (wr_ok && word == 3'd4) begin
            if (be[0]) prescale[7:0]  <= wdata[7:0];
            if (be[1]) prescale[15:8] <= wdata[15:8];
            pcnt <= 16'h0;
        end else if (!halt) begin
            pcnt <= tick ? 16'h0 : pcnt + 16'd1;
        end
    end
`else
    assign tick = !halt;
`endif

    // Read mux over the pre-update register values.
    always_comb begin
        rd_val = 32'h0;
        case (word)
            3'd0: rd_val = mtime[31:0];
            3'd1: rd_val = mtime[63:32];
            3'd2: rd_val = mtimecmp[31:0];
            3'd3: rd_val = mtimecmp[63:32];
`ifdef MTIMER_PRESCALER_EN
            3'd4: rd_val = {16'h0, prescale};
`endif
            default: rd_val = 32'h0;
        endcase
    end

    // MTIME: a write to either half suppresses the whole 64-bit increment that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime <= 64'h0;
        end else if (wr_ok && word == 3'd0) begin
            mtime[31:0] <= merge_be(mtime[31:0], wdata, be);
        end else if (wr_ok && word == 3'd1) begin
            mtime[63:32] <= merge_be(mtime[63:32], wdata, be);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // MTIMECMP byte-enabled writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (wr_ok && word == 3'd2) begin
            mtimecmp[31:0] <= merge_be(mtimecmp[31:0], wdata, be);
        end else if (wr_ok && word == 3'd3) begin
            mtimecmp[63:32] <= merge_be(mtimecmp[63:32], wdata, be);
        end
    end

    // Interrupt level compares the registered state, so it trails a register change by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer <= 1'b0;
        end else begin
            timer <= (mtime >= mtimecmp);
        end
    end

    // Bus response: one-cycle ack per strobe, data only for good reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack   <= 1'b0;
            fault <= 1'b0;
            rdata <= 32'h0;
        end else begin
            ack   <= access;
            fault <= bad;
            rdata <= rd_ok ? rd_val : 32'h0;
        end
    end

endmodule

// File: tb/tb_mtimer.sv
// tb/tb_mtimer.sv - directed table and sequence bench for mtimer
module tb_mtimer;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  be = 4'h0;
    logic [31:0] rdata;
    logic        ack;
    logic        fault;
    logic        halt = 1'b1;
    logic        timer;

    int passed = 0;
    int total  = 0;
    int edges  = 0;

    typedef struct {
        logic        s;
        logic        r;
        logic        w;
        logic [4:0]  off;
        logic [31:0] d;
        logic [3:0]  b;
        logic        e_ack;
        logic        e_fault;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [0:NVEC-1];

    mtimer #(.BASE(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .rd    (rd),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .be    (be),
        .rdata (rdata),
        .ack   (ack),
        .fault (fault),
        .halt  (halt),
        .timer (timer)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else passed++;
    endtask

    task automatic bus(input logic s, input logic r, input logic w, input logic [4:0] off,
                       input logic [31:0] d, input logic [3:0] b,
                       output logic a, output logic f, output logic [31:0] q);
        sel = s; rd = r; wr = w; addr = BASE + {27'h0, off}; wdata = d; be = b;
        @(posedge clk); #1;
        sel = 1'b0; rd = 1'b0; wr = 1'b0;
        a = ack; f = fault; q = rdata;
    endtask

    task automatic wr_word(input logic [4:0] off, input logic [31:0] d);
        logic a, f;
        logic [31:0] q;
        bus(1'b1, 1'b0, 1'b1, off, d, 4'hF, a, f, q);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] off, input logic [31:0] exp);
        logic a, f;
        logic [31:0] q;
        bus(1'b1, 1'b1, 1'b0, off, 32'h0, 4'h0, a, f, q);
        chk(name, {31'h0, a, f, q}, {31'h0, 1'b1, 1'b0, exp});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic a, f;
        logic [31:0] q;
        int guard;

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 5'h00, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 5'h04, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 5'h08, 32'h0,         4'h0, 1'b1, 1'b0, 32'hFFFF_FFFF};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 5'h0C, 32'h0,         4'h0, 1'b1, 1'b0, 32'hFFFF_FFFF};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 5'h00, 32'h1234_5600, 4'hF, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 5'h00, 32'h0000_00AA, 4'h1, 1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 5'h00, 32'h0,         4'h0, 1'b1, 1'b0, 32'h1234_56AA};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 5'h04, 32'hDEAD_BEEF, 4'hC, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 5'h04, 32'h0,         4'h0, 1'b1, 1'b0, 32'hDEAD_0000};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 5'h14, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 5'h00, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 5'h00, 32'h0,         4'h0, 1'b1, 1'b0, 32'h1234_56AA};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 5'h00, 32'h0,         4'h0, 1'b0, 1'b0, 32'h0};
`ifdef MTIMER_PRESCALER_EN
        vecs[13] = '{1'b1, 1'b1, 1'b0, 5'h10, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0};
`else
        vecs[13] = '{1'b1, 1'b1, 1'b0, 5'h10, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0};
`endif
        vecs[14] = '{1'b1, 1'b0, 1'b1, 5'h0C, 32'h0,         4'h3, 1'b1, 1'b0, 32'h0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 5'h0C, 32'h0,         4'h0, 1'b1, 1'b0, 32'hFFFF_0000};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 5'h1C, 32'h0,         4'h0, 1'b1, 1'b1, 32'h0};

        // Reset with the counter frozen so the register table is deterministic.
        halt = 1'b1;
        @(posedge clk); #1;
        do_reset();
        chk("reset_state", {30'h0, ack, fault, rdata, timer}, 64'h0);

        for (int i = 0; i < NVEC; i++) begin
            bus(vecs[i].s, vecs[i].r, vecs[i].w, vecs[i].off, vecs[i].d, vecs[i].b, a, f, q);
            chk($sformatf("vec%0d", i), {31'h0, a, f, q},
                {31'h0, vecs[i].e_ack, vecs[i].e_fault, vecs[i].e_rdata});
        end
        chk("table_timer_low", {63'h0, timer}, 64'h0);

        // Free-running count from reset.
        halt = 1'b0;
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        rd_chk("idle_count", 5'h00, 32'd10);
        rd_chk("idle_count_hi", 5'h04, 32'd0);

        // Compare at 20: MTIME reaches 20 at edge 20, timer seen after edge 21.
        wr_word(5'h08, 32'd20);
        wr_word(5'h0C, 32'd0);
        chk("timer_before_match", {63'h0, timer}, 64'h0);
        guard = 0;
        while (!timer && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("timer_rise_edge", 64'(edges), 64'd21);
        wr_word(5'h0C, 32'd1);
        chk("timer_hold_after_cmp_write", {63'h0, timer}, 64'h1);
        @(posedge clk); #1;
        chk("timer_fall", {63'h0, timer}, 64'h0);

        // Carry from the low word into the high word.
        wr_word(5'h00, 32'hFFFF_FFFE);
        wr_word(5'h04, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rd_chk("carry_hi", 5'h04, 32'h1);
        rd_chk("carry_lo", 5'h00, 32'h1);

        // A write beats the tick in the same cycle for either half.
        wr_word(5'h00, 32'd100);
        rd_chk("collide_lo_write", 5'h00, 32'd100);
        rd_chk("collide_lo_next", 5'h00, 32'd101);
        wr_word(5'h04, 32'd7);
        rd_chk("collide_hi_lo_held", 5'h00, 32'd102);
        rd_chk("collide_hi_value", 5'h04, 32'd7);
        @(posedge clk); #1;
        chk("ack_one_cycle", {62'h0, ack, fault}, 64'h0);

        // Halt freezes the counter but not the bus.
        halt = 1'b1;
        wr_word(5'h00, 32'd500);
        wr_word(5'h04, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        rd_chk("halt_lo", 5'h00, 32'd500);
        rd_chk("halt_hi", 5'h04, 32'd0);
        halt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd_chk("resume_count", 5'h00, 32'd503);

        // Reset during an access drops the pending ack.
        sel = 1'b1; rd = 1'b1; addr = BASE; rst_n = 1'b0;
        @(posedge clk); #1;
        sel = 1'b0; rd = 1'b0; rst_n = 1'b1;
        chk("reset_drops_ack", {30'h0, ack, fault, rdata, timer}, 64'h0);
        rd_chk("reset_mtime", 5'h00, 32'd0);

`ifdef MTIMER_PRESCALER_EN
        // PRESCALE=3: one tick per 4 cycles; upper bits ignored.
        halt = 1'b1;
        wr_word(5'h10, 32'hFFFF_0003);
        wr_word(5'h00, 32'd0);
        wr_word(5'h04, 32'd0);
        rd_chk("prescale_readback", 5'h10, 32'd3);
        halt = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rd_chk("prescale_count1", 5'h00, 32'd1);
        rd_chk("prescale_count2", 5'h00, 32'd2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
